// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial add sequencer (serial_adder_ctrl).
//   state_t    : sequencer states IDLE / RUN / DONE
//   cnt_w()    : width of the bit counter for a given operand width
//   WIDTH_MIN  : smallest operand width the sequencer supports
// ---------------------------------------------------------------------------
package serial_add_pkg;

   localparam int WIDTH_MIN = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter only ever has to reach WIDTH-1, so $clog2(WIDTH) bits are
   // enough; widths below the minimum are clamped so the counter is never
   // zero bits wide.
   function automatic int cnt_w(input int width);
      return $clog2((width < WIDTH_MIN) ? WIDTH_MIN : width);
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_fa
// The 1-bit full-adder cell that the serial sequencer time-multiplexes.
// When the enable is low both outputs are forced to 0.
// Ports:
//   i_en     in  1  cell enable
//   i_a      in  1  operand bit A
//   i_b      in  1  operand bit B
//   i_cin    in  1  carry in
//   o_sum    out 1  sum bit
//   o_carry  out 1  carry out
// ---------------------------------------------------------------------------
module serial_adder_ctrl_fa (
   input  logic i_en,
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_carry
);

   // Gating both outputs with the enable means an idle cell presents zeros,
   // so nothing downstream can pick up a stale bit outside of RUN.
   assign o_sum   = i_en & (i_a ^ i_b ^ i_cin);
   assign o_carry = i_en & ((i_a & i_b) | (i_a & i_cin) | (i_b & i_cin));

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial add sequencer: one full-adder cell is reused over WIDTH cycles,
// LSB first, with a carry flop chaining the bits. Operands arrive over a
// valid/ready handshake and the result leaves over another one.
//
// Optional feature macro: SERIAL_ADD_OVF_EN
//   defined   -> port ovf (signed overflow of the add) and its flop exist
//   undefined -> no ovf port; everything else behaves identically
//
// Parameters:
//   WIDTH      operand/sum width in bits (2..64), default 8
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   clr        in   1      synchronous abort back to IDLE
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry in
//   out_valid  out  1      sum/cout valid (DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of the MSB
//   busy       out  1      high in RUN or DONE
//   ovf        out  1      signed overflow (SERIAL_ADD_OVF_EN only)
// ---------------------------------------------------------------------------
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int             CNT_W    = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           r_state;
   state_t           w_stateNext;
   logic [WIDTH-1:0] r_aSh;
   logic [WIDTH-1:0] r_bSh;
   logic [WIDTH-1:0] r_sumSh;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;

   logic             w_run;
   logic             w_accept;
   logic             w_lastBit;
   logic             w_sumBit;
   logic             w_carryBit;

   assign w_run     = (r_state == RUN);
   assign w_accept  = (r_state == IDLE) && in_valid && !clr;
   assign w_lastBit = w_run && (r_cnt == CNT_LAST);

   // The one shared full-adder cell. It only sees real inputs in RUN; in the
   // other states its enable is low and it outputs zeros.
   serial_adder_ctrl_fa u_fa (
      .i_en    (w_run),
      .i_a     (r_aSh[0]),
      .i_b     (r_bSh[0]),
      .i_cin   (r_carry),
      .o_sum   (w_sumBit),
      .o_carry (w_carryBit)
   );

   // Next-state logic. clr overrides everything, including a pending accept
   // in IDLE. Leaving DONE always goes through IDLE, so a new operand can
   // only be taken on the cycle after the result handshake.
   always_comb begin
      w_stateNext = r_state;
      if (clr) begin
         w_stateNext = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (in_valid)  w_stateNext = RUN;
            RUN:     if (w_lastBit) w_stateNext = DONE;
            DONE:    if (out_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Datapath: operands are captured only at accept, then shifted right one
   // bit per RUN cycle while each sum bit enters the result register from the
   // top, so after WIDTH cycles bit 0 has landed in sum[0]. The counter holds
   // at WIDTH-1 on the last bit instead of wrapping. clr wipes the visible
   // result; the operand shifters are don't-care until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aSh   <= '0;
         r_bSh   <= '0;
         r_sumSh <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (clr) begin
         r_sumSh <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_aSh   <= a;
         r_bSh   <= b;
         r_carry <= cin;
         r_sumSh <= '0;
         r_cnt   <= '0;
      end else if (w_run) begin
         r_sumSh <= {w_sumBit, r_sumSh[WIDTH-1:1]};
         r_carry <= w_carryBit;
         r_aSh   <= r_aSh >> 1;
         r_bSh   <= r_bSh >> 1;
         if (!w_lastBit) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   logic r_ovf;

   // On the MSB cycle the carry flop holds the carry into the MSB and the
   // cell's carry output is the carry out of it; their XOR is signed
   // overflow. It is captured once and held through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (clr || w_accept) begin
         r_ovf <= 1'b0;
      end else if (w_lastBit) begin
         r_ovf <= r_carry ^ w_carryBit;
      end
   end

   assign ovf = r_ovf;
`endif

   // Handshake and status outputs are pure decodes of the state, and the
   // result comes straight from the flops, so it is stable throughout DONE.
   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN) || (r_state == DONE);
   assign sum       = r_sumSh;
   assign cout      = r_carry;

endmodule
